arith_uitofp_arbiter: RTL and testbench
=======================================

Name: arith_uitofp_arbiter

Overview:
- Shares one unsigned-int-to-float conversion datapath (arith_uitofp instance) among NUM_REQ requesters.
- Round-robin arbitration on valid/ready request ports, a LATENCY-deep registered pipeline after the converter, and a single tagged response port with backpressure.
- Sits between dataflow PEs emitting uitofp ops and the shared FP conversion resource.

Parameters:
- NUM_REQ, 4, number of requester ports (>=1)
- IN_WIDTH, 32, unsigned integer operand width
- OUT_WIDTH, 32, float result width; only 32 or 64 legal
- LATENCY, 2, registered stages from grant to resp_valid (>=1)
- ID_W (localparam), max(1,$clog2(NUM_REQ)), response tag width

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester operand valid
- req_data  input  NUM_REQ*IN_WIDTH  packed operands; requester i at [i*IN_WIDTH +: IN_WIDTH]
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
- resp_valid  output  1  result valid
- resp_data  output  OUT_WIDTH  converted float bits
- resp_id  output  ID_W  index of the requester that produced resp_data
- resp_ready  input  1  consumer accept
- busy  output  1  any pipeline stage holds a valid entry

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - All stage valids, resp_valid and busy are 0.
  - resp_data and resp_id are 0.
  - Round-robin pointer is 0.
  - req_ready is 0 while rst_n is low.
- Pipeline advance:
  - adv = !(resp_valid && !resp_ready).
  - When adv=0, every stage holds its value.
  - When adv=1, every stage shifts forward one position.
- Arbitration:
  - Grant goes to the first asserted req_valid searching upward from the pointer, with wrap-around.
  - req_ready[i] = grant[i] && adv. This is combinational on req_valid and resp_ready.
  - Requesters must not make req_valid depend on req_ready.
- Transfer:
  - Occurs when req_valid[i] && req_ready[i].
  - Stage 1 captures {1, conv(req_data[i]), i}, where conv is arith_uitofp with IN_WIDTH/OUT_WIDTH.
  - The pointer moves to (i+1) mod NUM_REQ.
  - With no transfer, the pointer is unchanged and stage 1 captures valid=0 when adv=1.
- Latency:
  - An operand accepted at edge N appears on resp_* after edge N+LATENCY-1, assuming no stalls.
  - LATENCY=1 means the result is visible the cycle after acceptance.
- Throughput: one conversion per cycle when resp_ready=1. Bubbles propagate and are not compacted.
- Ordering: responses leave in acceptance order. resp_id identifies the source.
- Output stability: while resp_valid=1 and resp_ready=0, resp_data and resp_id hold stable.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transfers.
- Simultaneous events:
  - A stalled output with an arriving request gives no grant and no pointer move.
  - resp handshake and new accept in the same cycle are both allowed and the pipeline shifts.
- Reset mid-operation: in-flight entries are discarded immediately (asynchronous). No partial response is ever emitted.
- Rounding: per the converter, round-to-nearest-even. IN_WIDTH > OUT_WIDTH is allowed.
- Elaboration errors: OUT_WIDTH not in {32,64}, NUM_REQ<1 or LATENCY<1 cause $fatal at elaboration.
- busy = OR of all stage valids.

Test Plan:
- Single requester: NUM_REQ=4, LATENCY=2, resp_ready=1; port 2 sends 1, 0, 0xFFFFFFFF, 16777217 back-to-back.
  - Required: resp_data 0x3F800000, 0x00000000, 0x4F800000, 0x4B800000 on consecutive cycles.
  - resp_id=2 for every response; first response 2 edges after the first accept.
- All four ports valid continuously with operands equal to the port index.
  - Required: resp_id sequence 0,1,2,3,0,1.
  - resp_data 0x00000000, 0x3F800000, 0x40000000, 0x40400000 repeating.
- Backpressure: resp_ready=0 for 5 cycles while requests pend.
  - Required: resp_data/resp_id stable, req_ready all 0, pointer unchanged.
  - After release: no loss or duplication, order preserved.
- Reset mid-operation: assert rst_n=0 with 2 entries in flight.
  - Required: resp_valid and busy drop to 0 asynchronously; pointer returns to 0.
  - After release: the first request from port 3 returns with resp_id=3.
- OUT_WIDTH=64, IN_WIDTH=64, LATENCY=1: operands 1 and 2^53+1.
  - Required: 0x3FF0000000000000 and 0x4340000000000000 one cycle after accept.
- NUM_REQ=1: ID_W=1, resp_id always 0; a continuous stream sustains 1 result per cycle.

Source files
------------

// File: rtl/arith_uitofp_arbiter.sv
// Round-robin arbiter sharing one unsigned-int to IEEE-754 float converter
// among NUM_REQ requesters, followed by a LATENCY-deep stall-able pipeline
// and a single tagged response port.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester operand valid
//   req_data     packed operands, requester i at [i*IN_WIDTH +: IN_WIDTH]
//   req_ready    per-requester accept (one-hot or zero, combinational)
//   resp_valid   result valid
//   resp_data    converted float bits
//   resp_id      index of the requester that produced resp_data
//   resp_ready   consumer accept
//   busy         any pipeline stage holds a valid entry

// Combinational unsigned integer to float conversion, round-to-nearest-even.
module arith_uitofp #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic [IN_WIDTH-1:0]  operand,
    output logic [OUT_WIDTH-1:0] result_c
);
    localparam int unsigned MW   = (OUT_WIDTH == 64) ? 52 : 23;
    localparam int unsigned EW   = OUT_WIDTH - MW - 1;
    localparam int unsigned BIAS = (1 << (EW - 1)) - 1;
    // Operand widened with mantissa + guard + one spare bit of zeros so the
    // slices below stay legal whether IN_WIDTH is above or below MW.
    localparam int unsigned XW   = IN_WIDTH + MW + 2;

    int unsigned   msb;
    logic [XW-1:0] ext;
    logic [MW-1:0] mant;
    logic [EW-1:0] expo;
    logic          guard;
    logic          sticky;
    logic          rnd;

    always_comb begin
        msb = 0;
        for (int unsigned b = 0; b < IN_WIDTH; b++) begin
            if (operand[b]) msb = b;
        end
        // Normalise so the leading one lands in the top bit of ext.
        ext    = {operand, {(MW + 2){1'b0}}} << (IN_WIDTH - 1 - msb);
        mant   = ext[XW-2 -: MW];
        guard  = ext[XW-2-MW];
        sticky = |ext[XW-3-MW:0];
        rnd    = guard & (sticky | mant[0]);
        expo   = EW'(msb + BIAS);
        // Mantissa carry-out from rounding ripples into the exponent.
        result_c = ext[XW-1] ? ({1'b0, expo, mant} + OUT_WIDTH'(rnd)) : '0;
    end
endmodule

module arith_uitofp_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned LATENCY   = 2,
    localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*IN_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          resp_valid,
    output logic [OUT_WIDTH-1:0]          resp_data,
    output logic [ID_W-1:0]               resp_id,
    input  logic                          resp_ready,
    output logic                          busy
);
    // Elaboration-time parameter checks.
    if (OUT_WIDTH != 32 && OUT_WIDTH != 64) begin : g_bad_out_width
        $fatal(1, "arith_uitofp_arbiter: OUT_WIDTH must be 32 or 64");
    end
    if (NUM_REQ < 1) begin : g_bad_num_req
        $fatal(1, "arith_uitofp_arbiter: NUM_REQ must be >= 1");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $fatal(1, "arith_uitofp_arbiter: LATENCY must be >= 1");
    end

    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      cand;
    logic [ID_W-1:0]      gidx;
    logic                 gany;
    logic                 adv;
    logic                 xfer;
    logic [IN_WIDTH-1:0]  sel_data;
    logic [OUT_WIDTH-1:0] conv;

    logic [LATENCY-1:0]   vld;
    logic [OUT_WIDTH-1:0] dat [LATENCY];
    logic [ID_W-1:0]      tag [LATENCY];

    // Whole pipeline moves unless the output holds an unaccepted result.
    assign adv  = !(vld[LATENCY-1] && !resp_ready);
    assign xfer = gany && adv;

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        gany = 1'b0;
        gidx = '0;
        cand = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr) + k) % NUM_REQ);
            if (!gany && req_valid[cand]) begin
                gany = 1'b1;
                gidx = cand;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gidx == ID_W'(k)) sel_data = req_data[k*IN_WIDTH +: IN_WIDTH];
        end
    end

    // Ready is forced low while reset is asserted.
    assign req_ready = (xfer && rst_n) ? (NUM_REQ'(1) << gidx) : '0;

    arith_uitofp #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_conv (
        .operand  (sel_data),
        .result_c (conv)
    );

    // Result pipeline and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            ptr <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat[i] <= '0;
                tag[i] <= '0;
            end
        end else if (adv) begin
            vld[0] <= xfer;
            if (xfer) begin
                dat[0] <= conv;
                tag[0] <= gidx;
                ptr    <= (32'(gidx) + 1 == NUM_REQ) ? '0 : ID_W'(32'(gidx) + 1);
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    assign resp_valid = vld[LATENCY-1];
    assign resp_data  = dat[LATENCY-1];
    assign resp_id    = tag[LATENCY-1];
    assign busy       = |vld;
endmodule

// File: tb/tb_arith_uitofp_arbiter.sv
// Directed, table-driven bench for arith_uitofp_arbiter: a 4-port 32-bit
// instance, a 2-port 64-bit LATENCY=1 instance and a single-port instance.
module tb_arith_uitofp_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 4 requesters, 32/32, latency 2
    logic [3:0]   a_valid;
    logic [127:0] a_data;
    logic [3:0]   a_ready;
    logic         a_rvalid;
    logic [31:0]  a_rdata;
    logic [1:0]   a_rid;
    logic         a_rready;
    logic         a_busy;

    // 2 requesters, 64/64, latency 1
    logic [1:0]   b_valid;
    logic [127:0] b_data;
    logic [1:0]   b_ready;
    logic         b_rvalid;
    logic [63:0]  b_rdata;
    logic [0:0]   b_rid;
    logic         b_rready;
    logic         b_busy;

    // 1 requester, 32/32, latency 2
    logic [0:0]   c_valid;
    logic [31:0]  c_data;
    logic [0:0]   c_ready;
    logic         c_rvalid;
    logic [31:0]  c_rdata;
    logic [0:0]   c_rid;
    logic         c_rready;
    logic         c_busy;

    arith_uitofp_arbiter #(.NUM_REQ(4), .IN_WIDTH(32), .OUT_WIDTH(32), .LATENCY(2)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_data(a_data),
        .req_ready(a_ready), .resp_valid(a_rvalid), .resp_data(a_rdata),
        .resp_id(a_rid), .resp_ready(a_rready), .busy(a_busy));

    arith_uitofp_arbiter #(.NUM_REQ(2), .IN_WIDTH(64), .OUT_WIDTH(64), .LATENCY(1)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_data(b_data),
        .req_ready(b_ready), .resp_valid(b_rvalid), .resp_data(b_rdata),
        .resp_id(b_rid), .resp_ready(b_rready), .busy(b_busy));

    arith_uitofp_arbiter #(.NUM_REQ(1), .IN_WIDTH(32), .OUT_WIDTH(32), .LATENCY(2)) u_c (
        .clk(clk), .rst_n(rst_n), .req_valid(c_valid), .req_data(c_data),
        .req_ready(c_ready), .resp_valid(c_rvalid), .resp_data(c_rdata),
        .resp_id(c_rid), .resp_ready(c_rready), .busy(c_busy));

    typedef struct {
        int          port;
        logic [63:0] operand;
        logic [63:0] expect_v;
    } vec_t;

    vec_t        t1 [4];
    vec_t        t5 [4];
    vec_t        t6 [5];
    logic [31:0] t2_exp [4];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        t1[0] = '{2, 64'd1,          64'h3F800000};
        t1[1] = '{2, 64'd0,          64'h00000000};
        t1[2] = '{2, 64'hFFFFFFFF,   64'h4F800000};
        t1[3] = '{2, 64'd16777217,   64'h4B800000};

        t2_exp[0] = 32'h00000000;
        t2_exp[1] = 32'h3F800000;
        t2_exp[2] = 32'h40000000;
        t2_exp[3] = 32'h40400000;

        t5[0] = '{0, 64'd1,                   64'h3FF0000000000000};
        t5[1] = '{0, 64'h0020000000000001,    64'h4340000000000000};
        t5[2] = '{1, 64'd3,                   64'h4008000000000000};
        t5[3] = '{1, 64'hFFFFFFFFFFFFFFFF,    64'h43F0000000000000};

        t6[0] = '{0, 64'd10, 64'h41200000};
        t6[1] = '{0, 64'd11, 64'h41300000};
        t6[2] = '{0, 64'd12, 64'h41400000};
        t6[3] = '{0, 64'd13, 64'h41500000};
        t6[4] = '{0, 64'd14, 64'h41600000};

        rst_n    = 1'b0;
        a_valid  = 4'hF; a_data = '0; a_rready = 1'b1;
        b_valid  = '0;   b_data = '0; b_rready = 1'b1;
        c_valid  = '0;   c_data = '0; c_rready = 1'b1;

        // Reset state
        #12;
        chk("rst_resp_valid", 64'(a_rvalid), 64'd0);
        chk("rst_busy",       64'(a_busy),   64'd0);
        chk("rst_resp_data",  64'(a_rdata),  64'd0);
        chk("rst_resp_id",    64'(a_rid),    64'd0);
        chk("rst_req_ready",  64'(a_ready),  64'd0);
        rst_n   = 1'b1;
        a_valid = '0;
        tick();

        // Single requester on port 2, back-to-back
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                a_valid = 4'b0100;
                a_data[t1[i].port*32 +: 32] = t1[i].operand[31:0];
            end else begin
                a_valid = '0;
            end
            #1;
            if (i < 4) chk("t1_ready", 64'(a_ready), 64'h4);
            tick();
            if (i == 0) begin
                chk("t1_first_latency", 64'(a_rvalid), 64'd0);
            end else begin
                chk("t1_valid", 64'(a_rvalid), 64'd1);
                chk("t1_data",  64'(a_rdata),  t1[i-1].expect_v);
                chk("t1_id",    64'(a_rid),    64'(t1[i-1].port));
            end
        end

        // Pulse reset so the pointer starts at 0
        rst_n = 1'b0; #2; rst_n = 1'b1; #2;

        // All four ports continuously valid, operand = port index
        for (int p = 0; p < 4; p++) a_data[p*32 +: 32] = 32'(p);
        a_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("t2_ready", 64'(a_ready), 64'(4'b0001 << (c % 4)));
            tick();
            if (c == 0) begin
                chk("t2_first_latency", 64'(a_rvalid), 64'd0);
            end else begin
                chk("t2_valid", 64'(a_rvalid), 64'd1);
                chk("t2_id",    64'(a_rid),    64'((c - 1) % 4));
                chk("t2_data",  64'(a_rdata),  64'(t2_exp[(c - 1) % 4]));
            end
        end

        // Backpressure: 5 stalled cycles with all requests pending
        a_rready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("t3_stall_ready", 64'(a_ready), 64'd0);
            tick();
            chk("t3_stall_valid", 64'(a_rvalid), 64'd1);
            chk("t3_stall_id",    64'(a_rid),    64'd2);
            chk("t3_stall_data",  64'(a_rdata),  64'h40000000);
            chk("t3_stall_busy",  64'(a_busy),   64'd1);
        end
        a_rready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("t3_rel_ready", 64'(a_ready), 64'(4'b0001 << (c % 4)));
            tick();
            chk("t3_rel_valid", 64'(a_rvalid), 64'd1);
            chk("t3_rel_id",    64'(a_rid),    64'((3 + c) % 4));
            chk("t3_rel_data",  64'(a_rdata),  64'(t2_exp[(3 + c) % 4]));
        end

        // Reset with two entries in flight
        a_valid = '0;
        #1;
        chk("t4_busy_before", 64'(a_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", 64'(a_rvalid), 64'd0);
        chk("t4_rst_busy",  64'(a_busy),   64'd0);
        a_valid = 4'b1000;
        #1;
        chk("t4_rst_ready", 64'(a_ready), 64'd0);
        rst_n   = 1'b1;
        a_valid = 4'b1010;
        #1;
        chk("t4_ptr_zero", 64'(a_ready), 64'b0010);
        a_valid = 4'b1000;
        a_data[3*32 +: 32] = 32'd7;
        #1;
        chk("t4_ready3", 64'(a_ready), 64'b1000);
        tick();
        chk("t4_no_partial", 64'(a_rvalid), 64'd0);
        a_valid = '0;
        tick();
        chk("t4_valid", 64'(a_rvalid), 64'd1);
        chk("t4_id",    64'(a_rid),    64'd3);
        chk("t4_data",  64'(a_rdata),  64'h40E00000);

        // 64-bit, LATENCY=1
        for (int i = 0; i < 4; i++) begin
            b_valid = 2'(1 << t5[i].port);
            b_data[t5[i].port*64 +: 64] = t5[i].operand;
            #1;
            chk("t5_ready", 64'(b_ready), 64'(1 << t5[i].port));
            tick();
            chk("t5_valid", 64'(b_rvalid), 64'd1);
            chk("t5_data",  b_rdata,       t5[i].expect_v);
            chk("t5_id",    64'(b_rid),    64'(t5[i].port));
        end
        b_valid = '0;

        // Single-requester instance, continuous stream
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                c_valid = 1'b1;
                c_data  = t6[i].operand[31:0];
            end else begin
                c_valid = 1'b0;
            end
            #1;
            if (i < 5) chk("t6_ready", 64'(c_ready), 64'd1);
            tick();
            if (i == 0) begin
                chk("t6_first_latency", 64'(c_rvalid), 64'd0);
            end else begin
                chk("t6_valid", 64'(c_rvalid), 64'd1);
                chk("t6_data",  64'(c_rdata),  t6[i-1].expect_v);
                chk("t6_id",    64'(c_rid),    64'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
